next_pc_ras: RTL and testbench

Parametrised program-counter unit for the single-cycle MIPS core. It supersedes the plain PC block and adds these capabilities:
- four next-PC modes, including jr/jalr register targets;
- a pipeline-style stall hold;
- a link-address output;
- a circular return-address stack (RAS) that checks every function return against the address pushed by its call.

Mismatches are flagged and counted for debug. The unit sits between the control unit/register file and instruction memory.

---
 rtl/next_pc_ras.sv | 137 +++++++++++++
 tb/tb_next_pc_ras.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/next_pc_ras.sv
// Program-counter unit for the single-cycle MIPS core. It provides four
// next-PC modes, a stall hold and a link address. A circular return-address
// stack checks each function return against the address its call pushed.
module next_pc_ras #(
  parameter logic [31:0] RESET_PC  = 32'h0000_3000,
  parameter int          RAS_DEPTH = 4,
  parameter int          CNT_W     = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic [1:0]       npc_mode,
  input  logic             cond,
  input  logic [15:0]      imm16,
  input  logic [25:0]      imm26,
  input  logic [31:0]      rs_val,
  input  logic             link,
  input  logic             ret,
  output logic [31:0]      pc,
  output logic [31:0]      pc_plus4,
  output logic [31:0]      npc,
  output logic             misalign,
  output logic             ras_valid,
  output logic [31:0]      ras_top,
  output logic             ras_mismatch,
  output logic [CNT_W-1:0] mismatch_cnt
);

  localparam int PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int OCC_W = PTR_W + 1;
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [OCC_W-1:0] OCC_ONE  = OCC_W'(1);
  localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(RAS_DEPTH);

  logic [31:0]      ras_mem [RAS_DEPTH];
  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] top_idx;
  logic [OCC_W-1:0] count;
  logic [31:0]      branch_off;
  logic             push_op;
  logic             swap_op;
  logic             pop_op;
  logic             wr_en;
  logic [PTR_W-1:0] wr_idx;

  assign pc_plus4   = pc + 32'd4;
  assign branch_off = {{14{imm16[15]}}, imm16, 2'b00};

  // Next-PC selection; register targets always have their low bits cleared.
  always_comb begin
    npc = pc_plus4;
    case (npc_mode)
      2'b00: npc = pc_plus4;
      2'b01: npc = cond ? (pc_plus4 + branch_off) : pc_plus4;
      2'b10: npc = {pc_plus4[31:28], imm26, 2'b00};
      2'b11: npc = {rs_val[31:2], 2'b00};
      default: npc = pc_plus4;
    endcase
  end

  assign misalign     = (npc_mode == 2'b11) && (rs_val[1:0] != 2'b00);
  assign top_idx      = ptr - PTR_ONE;
  assign ras_valid    = (count != '0);
  assign ras_top      = ras_valid ? ras_mem[top_idx] : 32'd0;
  assign ras_mismatch = ret & ras_valid & (npc != ras_top);

  // Decode stack operation: link+ret on an empty stack degrades to a push.
  always_comb begin
    push_op = 1'b0;
    swap_op = 1'b0;
    pop_op  = 1'b0;
    wr_en   = 1'b0;
    wr_idx  = ptr;
    if (!stall) begin
      if (link && (!ret || !ras_valid)) begin
        push_op = 1'b1;
        wr_en   = 1'b1;
        wr_idx  = ptr;
      end else if (link && ret) begin
        swap_op = 1'b1;
        wr_en   = 1'b1;
        wr_idx  = top_idx;
      end else if (ret && ras_valid) begin
        pop_op = 1'b1;
      end
    end
  end

  // PC register: hold on stall, otherwise load the next PC.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc <= RESET_PC;
    end else if (!stall) begin
      pc <= npc;
    end
  end

  // Stack entries, one register per slot written with the link address.
  genvar gi;
  generate
    for (gi = 0; gi < RAS_DEPTH; gi++) begin : g_entry
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          ras_mem[gi] <= 32'd0;
        end else if (wr_en && (wr_idx == PTR_W'(gi))) begin
          ras_mem[gi] <= pc_plus4;
        end
      end
    end
  endgenerate

  // Stack pointer and occupancy; a push on a full stack overwrites the oldest.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr   <= '0;
      count <= '0;
    end else if (push_op) begin
      ptr <= ptr + PTR_ONE;
      if (count != OCC_FULL) begin
        count <= count + OCC_ONE;
      end
    end else if (pop_op) begin
      ptr   <= ptr - PTR_ONE;
      count <= count - OCC_ONE;
    end
  end

  // Saturating count of mismatches seen on non-stalled cycles.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mismatch_cnt <= '0;
    end else if (!stall && ras_mismatch && (mismatch_cnt != '1)) begin
      mismatch_cnt <= mismatch_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_next_pc_ras.sv
// Directed bench for next_pc_ras: a vector table walked cycle by cycle,
// plus sequences for asynchronous reset and counter saturation.
module tb_next_pc_ras;

  typedef struct {
    logic        stall;
    logic [1:0]  mode;
    logic        cond;
    logic [15:0] imm16;
    logic [25:0] imm26;
    logic [31:0] rs;
    logic        link;
    logic        ret;
    logic [31:0] e_npc;
    logic        e_mis;
    logic        e_rmm;
    logic [31:0] e_pc;
    logic        e_valid;
    logic [31:0] e_top;
    logic [7:0]  e_cnt;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset, stall, cond, link, ret;
  logic [1:0]  npc_mode;
  logic [15:0] imm16;
  logic [25:0] imm26;
  logic [31:0] rs_val;
  logic [31:0] pc, pc_plus4, npc, ras_top;
  logic        misalign, ras_valid, ras_mismatch;
  logic [7:0]  mismatch_cnt;

  logic        reset2, stall2, cond2, link2, ret2;
  logic [1:0]  npc_mode2;
  logic [15:0] imm16_2;
  logic [25:0] imm26_2;
  logic [31:0] rs_val2;
  logic [31:0] pc2, pc_plus4_2, npc2, ras_top2;
  logic        misalign2, ras_valid2, ras_mismatch2;
  logic [1:0]  mismatch_cnt2;

  int checks = 0;
  int errors = 0;
  vec_t vec [38];

  always #5 clk = ~clk;

  next_pc_ras dut (
    .clk(clk), .reset(reset), .stall(stall), .npc_mode(npc_mode), .cond(cond),
    .imm16(imm16), .imm26(imm26), .rs_val(rs_val), .link(link), .ret(ret),
    .pc(pc), .pc_plus4(pc_plus4), .npc(npc), .misalign(misalign),
    .ras_valid(ras_valid), .ras_top(ras_top), .ras_mismatch(ras_mismatch),
    .mismatch_cnt(mismatch_cnt)
  );

  next_pc_ras #(.CNT_W(2)) dut2 (
    .clk(clk), .reset(reset2), .stall(stall2), .npc_mode(npc_mode2), .cond(cond2),
    .imm16(imm16_2), .imm26(imm26_2), .rs_val(rs_val2), .link(link2), .ret(ret2),
    .pc(pc2), .pc_plus4(pc_plus4_2), .npc(npc2), .misalign(misalign2),
    .ras_valid(ras_valid2), .ras_top(ras_top2), .ras_mismatch(ras_mismatch2),
    .mismatch_cnt(mismatch_cnt2)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic s, input logic [1:0] m, input logic c,
                              input logic [15:0] i16, input logic [25:0] i26,
                              input logic [31:0] r, input logic l, input logic rt,
                              input logic [31:0] en, input logic em, input logic er,
                              input logic [31:0] ep, input logic ev,
                              input logic [31:0] et, input logic [7:0] ec);
    vec_t v;
    v.stall = s; v.mode = m; v.cond = c; v.imm16 = i16; v.imm26 = i26;
    v.rs = r; v.link = l; v.ret = rt; v.e_npc = en; v.e_mis = em; v.e_rmm = er;
    v.e_pc = ep; v.e_valid = ev; v.e_top = et; v.e_cnt = ec;
    return v;
  endfunction

  initial begin
    // sequential, branch, jump, stall
    vec[0]  = mk(0,0,0,0,0,0,0,0, 32'h3004,0,0, 32'h3004,0,0,0);
    vec[1]  = mk(0,0,0,0,0,0,0,0, 32'h3008,0,0, 32'h3008,0,0,0);
    vec[2]  = mk(0,0,0,0,0,0,0,0, 32'h300C,0,0, 32'h300C,0,0,0);
    vec[3]  = mk(0,3,0,0,0,32'h3000,0,0, 32'h3000,0,0, 32'h3000,0,0,0);
    vec[4]  = mk(0,1,1,16'h0001,0,0,0,0, 32'h3008,0,0, 32'h3008,0,0,0);
    vec[5]  = mk(0,3,0,0,0,32'h3000,0,0, 32'h3000,0,0, 32'h3000,0,0,0);
    vec[6]  = mk(0,1,1,16'hFFFF,0,0,0,0, 32'h3000,0,0, 32'h3000,0,0,0);
    vec[7]  = mk(0,1,0,16'hFFFF,0,0,0,0, 32'h3004,0,0, 32'h3004,0,0,0);
    vec[8]  = mk(0,3,0,0,0,32'h3000,0,0, 32'h3000,0,0, 32'h3000,0,0,0);
    vec[9]  = mk(0,2,0,0,26'hC10,0,0,0, 32'h3040,0,0, 32'h3040,0,0,0);
    vec[10] = mk(1,0,0,0,0,0,0,0, 32'h3044,0,0, 32'h3040,0,0,0);
    vec[11] = mk(1,0,0,0,0,0,0,0, 32'h3044,0,0, 32'h3040,0,0,0);
    vec[12] = mk(1,0,0,0,0,0,0,0, 32'h3044,0,0, 32'h3040,0,0,0);
    vec[13] = mk(0,3,0,0,0,32'h3000,0,0, 32'h3000,0,0, 32'h3000,0,0,0);
    // call / return
    vec[14] = mk(0,2,0,0,26'hC10,0,1,0, 32'h3040,0,0, 32'h3040,1,32'h3004,0);
    vec[15] = mk(0,0,0,0,0,0,0,0, 32'h3044,0,0, 32'h3044,1,32'h3004,0);
    vec[16] = mk(0,3,0,0,0,32'h3004,0,1, 32'h3004,0,0, 32'h3004,0,0,0);
    vec[17] = mk(0,2,0,0,26'hC10,0,1,0, 32'h3040,0,0, 32'h3040,1,32'h3008,0);
    vec[18] = mk(0,3,0,0,0,32'h3010,0,1, 32'h3010,0,1, 32'h3010,0,0,1);
    // five pushes into a four-deep stack, then pops and underflow
    vec[19] = mk(0,3,0,0,0,32'h3000,0,0, 32'h3000,0,0, 32'h3000,0,0,1);
    vec[20] = mk(0,0,0,0,0,0,1,0, 32'h3004,0,0, 32'h3004,1,32'h3004,1);
    vec[21] = mk(0,0,0,0,0,0,1,0, 32'h3008,0,0, 32'h3008,1,32'h3008,1);
    vec[22] = mk(0,0,0,0,0,0,1,0, 32'h300C,0,0, 32'h300C,1,32'h300C,1);
    vec[23] = mk(0,0,0,0,0,0,1,0, 32'h3010,0,0, 32'h3010,1,32'h3010,1);
    vec[24] = mk(0,0,0,0,0,0,1,0, 32'h3014,0,0, 32'h3014,1,32'h3014,1);
    vec[25] = mk(0,3,0,0,0,32'h3014,0,1, 32'h3014,0,0, 32'h3014,1,32'h3010,1);
    vec[26] = mk(0,3,0,0,0,32'h3010,0,1, 32'h3010,0,0, 32'h3010,1,32'h300C,1);
    vec[27] = mk(0,3,0,0,0,32'h300C,0,1, 32'h300C,0,0, 32'h300C,1,32'h3008,1);
    vec[28] = mk(0,3,0,0,0,32'h3008,0,1, 32'h3008,0,0, 32'h3008,0,0,1);
    vec[29] = mk(0,3,0,0,0,32'h3004,0,1, 32'h3004,0,0, 32'h3004,0,0,1);
    // misalign, link+ret replace, stalled mismatch, pc wrap
    vec[30] = mk(0,3,0,0,0,32'h3007,0,0, 32'h3004,1,0, 32'h3004,0,0,1);
    vec[31] = mk(0,0,0,0,0,0,1,0, 32'h3008,0,0, 32'h3008,1,32'h3008,1);
    vec[32] = mk(0,3,0,0,0,32'h3100,1,1, 32'h3100,0,1, 32'h3100,1,32'h300C,2);
    vec[33] = mk(1,3,0,0,0,32'h3200,0,1, 32'h3200,0,1, 32'h3100,1,32'h300C,2);
    vec[34] = mk(0,3,0,0,0,32'hFFFF_FFFC,0,0, 32'hFFFF_FFFC,0,0, 32'hFFFF_FFFC,1,32'h300C,2);
    vec[35] = mk(0,0,0,0,0,0,0,0, 32'h0,0,0, 32'h0,1,32'h300C,2);
    vec[36] = mk(0,2,0,0,26'hC00,0,0,0, 32'h3000,0,0, 32'h3000,1,32'h300C,2);
    vec[37] = mk(0,0,0,0,0,0,0,0, 32'h3004,0,0, 32'h3004,1,32'h300C,2);

    reset = 1'b0; stall = 0; npc_mode = 0; cond = 0; imm16 = 0; imm26 = 0;
    rs_val = 0; link = 0; ret = 0;
    reset2 = 1'b0; stall2 = 0; npc_mode2 = 2'b11; cond2 = 0; imm16_2 = 0;
    imm26_2 = 0; rs_val2 = 32'h3100; link2 = 1; ret2 = 1;

    repeat (2) @(negedge clk);
    chk("reset_pc", pc, 32'h3000);
    chk("reset_valid", {31'd0, ras_valid}, 32'd0);
    chk("reset_top", ras_top, 32'd0);
    chk("reset_cnt", {24'd0, mismatch_cnt}, 32'd0);
    reset = 1'b1;

    for (int i = 0; i < 38; i++) begin
      stall = vec[i].stall; npc_mode = vec[i].mode; cond = vec[i].cond;
      imm16 = vec[i].imm16; imm26 = vec[i].imm26; rs_val = vec[i].rs;
      link = vec[i].link; ret = vec[i].ret;
      #1;
      chk($sformatf("v%0d_npc", i), npc, vec[i].e_npc);
      chk($sformatf("v%0d_misalign", i), {31'd0, misalign}, {31'd0, vec[i].e_mis});
      chk($sformatf("v%0d_ras_mismatch", i), {31'd0, ras_mismatch}, {31'd0, vec[i].e_rmm});
      @(posedge clk); #1;
      chk($sformatf("v%0d_pc", i), pc, vec[i].e_pc);
      chk($sformatf("v%0d_pc_plus4", i), pc_plus4, vec[i].e_pc + 32'd4);
      chk($sformatf("v%0d_ras_valid", i), {31'd0, ras_valid}, {31'd0, vec[i].e_valid});
      chk($sformatf("v%0d_ras_top", i), ras_top, vec[i].e_top);
      chk($sformatf("v%0d_cnt", i), {24'd0, mismatch_cnt}, {24'd0, vec[i].e_cnt});
      $display("vec %0d: pc=%h npc=%h ras_valid=%0d ras_top=%h cnt=%0d",
               i, pc, npc, ras_valid, ras_top, mismatch_cnt);
      @(negedge clk);
    end

    // Asynchronous reset between clock edges clears state immediately.
    @(posedge clk); #3;
    reset = 1'b0;
    #1;
    chk("async_pc", pc, 32'h3000);
    chk("async_valid", {31'd0, ras_valid}, 32'd0);
    chk("async_top", ras_top, 32'd0);
    chk("async_cnt", {24'd0, mismatch_cnt}, 32'd0);
    $display("async reset: pc=%h ras_valid=%0d cnt=%0d", pc, ras_valid, mismatch_cnt);
    @(negedge clk);
    reset = 1'b1; stall = 0; npc_mode = 0; link = 0; ret = 0;
    @(posedge clk); #1;
    chk("post_reset_pc", pc, 32'h3004);
    $display("post reset: pc=%h", pc);

    // Narrow counter: repeated link+ret mismatches must saturate at 3.
    @(negedge clk);
    reset2 = 1'b1;
    for (int k = 0; k < 6; k++) begin
      #1;
      chk($sformatf("sat%0d_rmm", k), {31'd0, ras_mismatch2}, (k == 0) ? 32'd0 : 32'd1);
      @(posedge clk); #1;
      chk($sformatf("sat%0d_cnt", k), {30'd0, mismatch_cnt2}, (k > 3) ? 32'd3 : k);
      $display("sat %0d: pc=%h ras_top=%h cnt=%0d", k, pc2, ras_top2, mismatch_cnt2);
      @(negedge clk);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
